// File: rtl/green_diff_window_ctrl_pkg.sv
// Shared CFA definitions for the green-gradient window sequencer.
// FSM encoding, default sample width and a constant clog2 helper.
package green_diff_window_ctrl_pkg;

  localparam int PIXEL_BW_DEF = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/green_diff_window_ctrl_if.sv
// Sample-in / result-out handshake bundle for the window sequencer.
// Slave is the sequencer side, master is the producer/consumer side.
interface green_diff_window_ctrl_if
  import green_diff_window_ctrl_pkg::*;
#(
  parameter int PIXEL_BW = PIXEL_BW_DEF,
  parameter int SUM_BW   = 16
);

  logic                in_valid;
  logic                in_ready;
  logic [PIXEL_BW-1:0] green_h;
  logic [PIXEL_BW-1:0] green_v;
  logic                out_valid;
  logic                out_ready;
  logic [SUM_BW-1:0]   diff_sum;
  logic [PIXEL_BW-2:0] max_diff;
  logic                smooth;

  modport master (
    output in_valid, green_h, green_v, out_ready,
    input  in_ready, out_valid, diff_sum, max_diff, smooth
  );

  modport slave (
    input  in_valid, green_h, green_v, out_ready,
    output in_ready, out_valid, diff_sum, max_diff, smooth
  );

endinterface

// File: rtl/green_diff_window_ctrl_abs_diff.sv
// Combinational |a - b|, computed at full width and truncated by one bit.
// An input with its MSB set yields the wrapped result silently.
module green_diff_window_ctrl_abs_diff #(
  parameter int PIXEL_BW = 14
) (
  input  logic [PIXEL_BW-1:0] a,
  input  logic [PIXEL_BW-1:0] b,
  output logic [PIXEL_BW-2:0] d
);

  localparam int DW = PIXEL_BW - 1;

  logic [PIXEL_BW-1:0] diff;

  assign diff = a - b;
  assign d = diff[PIXEL_BW-1] ?
             (~diff[DW-1:0]) + DW'(1) :
             diff[DW-1:0];

endmodule

// File: rtl/green_diff_window_ctrl.sv
// Windowed accumulation of |green_h - green_v| with sum, max and
// smoothness result held under downstream backpressure.
module green_diff_window_ctrl
  import green_diff_window_ctrl_pkg::*;
#(
  parameter int PIXEL_BW = PIXEL_BW_DEF,
  parameter int WIN      = 5,
  parameter int SUM_BW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [SUM_BW-1:0] thresh,
  output logic              busy,
  green_diff_window_ctrl_if.slave bus
);

  localparam int DW     = PIXEL_BW - 1;
  localparam int CNT_BW = clog2(WIN + 1);

  if (WIN < 2 || WIN > 64) begin : g_win_chk
    $error("WIN must lie in 2..64");
  end

  if (SUM_BW < DW + clog2(WIN)) begin : g_sum_chk
    $error("SUM_BW too narrow for WIN");
  end

  state_e state_q;
  state_e state_d;

  logic [SUM_BW-1:0] acc_q;
  logic [DW-1:0]     max_q;
  logic [CNT_BW-1:0] cnt_q;
  logic [SUM_BW-1:0] thr_q;
  logic [SUM_BW-1:0] sum_q;
  logic [DW-1:0]     maxo_q;
  logic              smooth_q;

  logic [DW-1:0]     d;
  logic [DW-1:0]     max_nxt;
  logic [SUM_BW-1:0] acc_nxt;
  logic              in_fire;
  logic              last;

  green_diff_window_ctrl_abs_diff #(
    .PIXEL_BW(PIXEL_BW)
  ) u_abs_diff (
    .a(bus.green_h),
    .b(bus.green_v),
    .d(d)
  );

  assign in_fire = (state_q == ACCUM) && bus.in_valid;
  assign last    = cnt_q == CNT_BW'(WIN - 1);
  assign acc_nxt = acc_q + SUM_BW'(d);
  assign max_nxt = (d > max_q) ? d : max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (1'b1)
        (state_q == IDLE):
          if (start) state_d = ACCUM;
        (state_q == ACCUM):
          if (in_fire && last) state_d = HOLD;
        (state_q == HOLD):
          if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = state_q == ACCUM;
    bus.out_valid = state_q == HOLD;
    busy          = state_q != IDLE;
  end

  // Result registers survive clear; only the running state is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      thr_q    <= '0;
      sum_q    <= '0;
      maxo_q   <= '0;
      smooth_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      acc_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
      thr_q <= thresh;
    end else if (in_fire) begin
      acc_q <= acc_nxt;
      max_q <= max_nxt;
      cnt_q <= cnt_q + CNT_BW'(1);
      if (last) begin
        sum_q    <= acc_nxt;
        maxo_q   <= max_nxt;
        smooth_q <= acc_nxt < thr_q;
      end
    end
  end

  assign bus.diff_sum = sum_q;
  assign bus.max_diff = maxo_q;
  assign bus.smooth   = smooth_q;

endmodule

// File: tb/tb_green_diff_window_ctrl.sv
// Scoreboard bench: stimulus pushes expected window results, a monitor
// pops and compares on every output handshake.
module tb_green_diff_window_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic [12:0] mx;
    logic        sm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] thresh = '0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        q[$];
  logic [13:0] ph[5];
  logic [13:0] pv[5];

  green_diff_window_ctrl_if #(.PIXEL_BW(14), .SUM_BW(16)) bus ();

  green_diff_window_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clear (clear),
    .thresh(thresh),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] thr);
    int s;
    int m;
    int a;
    exp_t e;
    s = 0;
    m = 0;
    for (int i = 0; i < 5; i++) begin
      a = int'(ph[i]) - int'(pv[i]);
      if (a < 0) a = -a;
      a = a % 8192;
      s += a;
      if (a > m) m = a;
    end
    e.sum = 16'(s);
    e.mx  = 13'(m);
    e.sm  = s < int'(thr);
    return e;
  endfunction

  task automatic set_pairs(input logic [13:0] h, input logic [13:0] v);
    for (int i = 0; i < 5; i++) begin
      ph[i] = h;
      pv[i] = v;
    end
  endtask

  task automatic do_start(input logic [15:0] thr);
    tick();
    start  = 1'b1;
    thresh = thr;
    tick();
    start  = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_after_start", bus.in_ready, 1);
  endtask

  task automatic send(input logic [13:0] h, input logic [13:0] v);
    int t;
    tick();
    bus.in_valid = 1'b1;
    bus.green_h  = h;
    bus.green_v  = v;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("in_ready_wait", bus.in_ready, 1);
  endtask

  task automatic finish_in();
    tick();
    bus.in_valid = 1'b0;
    chk("ov_after_last", bus.out_valid, 1);
    chk("ir_after_last", bus.in_ready, 0);
  endtask

  task automatic run_win(input logic [15:0] thr, input bit gap);
    do_start(thr);
    for (int i = 0; i < 5; i++) begin
      send(ph[i], pv[i]);
      if (gap && i < 4) begin
        tick();
        bus.in_valid = 1'b0;
      end
    end
    finish_in();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 20) begin
      tick();
      t++;
    end
    chk("back_to_idle", busy, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", bus.out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("diff_sum", bus.diff_sum, e.sum);
          chk("max_diff", bus.max_diff, e.mx);
          chk("smooth", bus.smooth, e.sm);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    logic [13:0] tmp;
    bus.in_valid  = 1'b0;
    bus.green_h   = '0;
    bus.green_v   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff_sum", bus.diff_sum, 0);
    chk("rst_max_diff", bus.max_diff, 0);
    chk("rst_smooth", bus.smooth, 0);

    // nominal window, back to back
    ph = '{14'd100, 14'd90, 14'd0, 14'd8191, 14'd5};
    pv = '{14'd90, 14'd100, 14'd0, 14'd0, 14'd7};
    q.push_back('{16'd8213, 13'd8191, 1'b1});
    run_win(16'd9000, 1'b0);
    wait_idle();

    // backpressure: hold 10 cycles, start ignored
    q.push_back('{16'd8213, 13'd8191, 1'b1});
    bus.out_ready = 1'b0;
    run_win(16'd9000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      start = (i == 4);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_sum", bus.diff_sum, 16'd8213);
      chk("bp_max", bus.max_diff, 13'd8191);
    end
    tick();
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_release_ov", bus.out_valid, 0);
    chk("bp_release_busy", busy, 0);

    // gapped input
    set_pairs(14'd8191, 14'd0);
    q.push_back('{16'd40955, 13'd8191, 1'b0});
    run_win(16'd40955, 1'b1);
    wait_idle();

    // abort after 3 accepts, clear racing a 4th accept
    do_start(16'd100);
    for (int i = 0; i < 3; i++) send(14'd1, 14'd2);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", bus.in_ready, 0);
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_keep_sum", bus.diff_sum, 16'd40955);
    tick();
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start_idle", busy, 0);
    set_pairs(14'd1, 14'd0);
    q.push_back('{16'd5, 13'd1, 1'b1});
    run_win(16'd6, 1'b0);
    wait_idle();

    // async reset while holding a result
    set_pairs(14'd3, 14'd1);
    bus.out_ready = 1'b0;
    run_win(16'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_diff_sum", bus.diff_sum, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    set_pairs(14'd2, 14'd0);
    q.push_back('{16'd10, 13'd2, 1'b1});
    run_win(16'd11, 1'b0);
    wait_idle();

    // swap symmetry against the reference model
    for (int i = 0; i < 5; i++) begin
      ph[i] = 14'($urandom_range(0, 8191));
      pv[i] = 14'($urandom_range(0, 8191));
    end
    e = model(16'd0);
    q.push_back(model(e.sum));
    run_win(e.sum, 1'b0);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      tmp   = ph[i];
      ph[i] = pv[i];
      pv[i] = tmp;
    end
    q.push_back(model(e.sum + 16'd1));
    run_win(e.sum + 16'd1, 1'b0);
    wait_idle();

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
